// File: rtl/b8_issue_pkg.sv
// Shared issue-stage types and sizes.
// Pure declarations; no latency or backpressure of its own.
package b8_issue_pkg;
  localparam int PID_W      = 2;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_SPLIT = 1'b1
  } issue_state_e;
endpackage

// File: rtl/issue_scoreboard.sv
// Busy bits for long-latency destinations, two issue set ports and one writeback clear.
// Updates land one cycle after the request; always accepts, no backpressure.
module issue_scoreboard
  import b8_issue_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set0_vld,
  input  logic [REG_ADDR_W-1:0] set0_addr,
  input  logic                  set1_vld,
  input  logic [REG_ADDR_W-1:0] set1_addr,
  input  logic                  clr_vld,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  clr_all,
  output logic [REG_NUM-1:0]    busy
);
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;

  // x0 is hardwired and never tracked
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set0_vld && set0_addr != '0) set_mask[set0_addr] = 1'b1;
    if (set1_vld && set1_addr != '0) set_mask[set1_addr] = 1'b1;
    if (clr_vld && clr_addr != '0)   clr_mask[clr_addr]   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        busy <= '0;
    else if (clr_all) busy <= '0;
    else              busy <= (busy & ~clr_mask) | set_mask;
  end
endmodule

// File: rtl/du_issue_ctrl.sv
// Dual-issue control: issues a decoded pair whole or split around RAW/WAW/busy hazards.
// Issue decision is combinational in the presenting cycle; state updates on the next edge.
// exReady_i low or pairValid_i low holds everything; flush_i overrides and clears.
module du_issue_ctrl
  import b8_issue_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pairValid_i,
  input  logic                  way1Valid_i,
  input  logic [REG_ADDR_W-1:0] way0_rs1Addr_i,
  input  logic [REG_ADDR_W-1:0] way0_rs2Addr_i,
  input  logic [REG_ADDR_W-1:0] way0_rdAddr_i,
  input  logic                  way0_rs1Use_i,
  input  logic                  way0_rs2Use_i,
  input  logic                  way0_rdWriteEnable_i,
  input  logic                  way0_longLat_i,
  input  logic [REG_ADDR_W-1:0] way1_rs1Addr_i,
  input  logic [REG_ADDR_W-1:0] way1_rs2Addr_i,
  input  logic [REG_ADDR_W-1:0] way1_rdAddr_i,
  input  logic                  way1_rs1Use_i,
  input  logic                  way1_rs2Use_i,
  input  logic                  way1_rdWriteEnable_i,
  input  logic                  way1_longLat_i,
  input  logic                  exReady_i,
  input  logic                  wbValid_i,
  input  logic [REG_ADDR_W-1:0] wbRdAddr_i,
  input  logic                  flush_i,
  output logic                  pairReady_o,
  output logic                  duLoad_o,
  output logic                  way0_valid_o,
  output logic                  way1_valid_o,
  output logic [PID_W-1:0]      way0_pID_o,
  output logic [PID_W-1:0]      way1_pID_o,
  output logic [31:0]           stallCycles_o
);
  issue_state_e       state, state_nxt;
  logic [PID_W-1:0]   cnt;
  logic [REG_NUM-1:0] busy;
  logic               src_busy0, src_busy1, raw1, waw1;
  logic               go, issue0, issue1, pair_ready;
  logic [PID_W-1:0]   issue_cnt;

  assign src_busy0 = (way0_rs1Use_i && way0_rs1Addr_i != '0 && busy[way0_rs1Addr_i]) ||
                     (way0_rs2Use_i && way0_rs2Addr_i != '0 && busy[way0_rs2Addr_i]);
  assign src_busy1 = (way1_rs1Use_i && way1_rs1Addr_i != '0 && busy[way1_rs1Addr_i]) ||
                     (way1_rs2Use_i && way1_rs2Addr_i != '0 && busy[way1_rs2Addr_i]);
  assign raw1 = way0_rdWriteEnable_i && way0_rdAddr_i != '0 &&
                ((way1_rs1Use_i && way1_rs1Addr_i == way0_rdAddr_i) ||
                 (way1_rs2Use_i && way1_rs2Addr_i == way0_rdAddr_i));
  assign waw1 = way0_rdWriteEnable_i && way1_rdWriteEnable_i &&
                way0_rdAddr_i == way1_rdAddr_i && way0_rdAddr_i != '0;

  assign go = !reset && !flush_i && exReady_i && pairValid_i;

  always_comb begin
    issue0     = 1'b0;
    issue1     = 1'b0;
    pair_ready = 1'b0;
    state_nxt  = state;
    if (go) begin
      case (state)
        ST_RUN: begin
          if (!src_busy0) begin
            issue0 = 1'b1;
            if (way1Valid_i && (src_busy1 || raw1 || waw1)) begin
              state_nxt = ST_SPLIT;
            end else begin
              issue1     = way1Valid_i;
              pair_ready = 1'b1;
            end
          end
        end
        // way0 already left, so only the scoreboard can block way1 now
        ST_SPLIT: begin
          if (!src_busy1) begin
            issue1     = 1'b1;
            pair_ready = 1'b1;
            state_nxt  = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign issue_cnt     = PID_W'(issue0) + PID_W'(issue1);
  assign way0_valid_o  = issue0;
  assign way1_valid_o  = issue1;
  assign way0_pID_o    = issue0 ? cnt : '0;
  assign way1_pID_o    = issue1 ? (issue0 ? cnt + PID_W'(1) : cnt) : '0;
  assign pairReady_o   = pair_ready;
  assign duLoad_o      = !reset && (exReady_i || flush_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      cnt           <= '0;
      stallCycles_o <= '0;
    end else if (flush_i) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt + issue_cnt;
      if (pairValid_i && exReady_i && !issue0 && !issue1 && stallCycles_o != '1)
        stallCycles_o <= stallCycles_o + 32'd1;
    end
  end

  issue_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set0_vld  (issue0 && way0_longLat_i && way0_rdWriteEnable_i),
    .set0_addr (way0_rdAddr_i),
    .set1_vld  (issue1 && way1_longLat_i && way1_rdWriteEnable_i),
    .set1_addr (way1_rdAddr_i),
    .clr_vld   (wbValid_i),
    .clr_addr  (wbRdAddr_i),
    .clr_all   (flush_i),
    .busy      (busy)
  );
endmodule

// File: tb/tb_du_issue_ctrl.sv
// Scoreboard bench: directed scenarios then random pairs, checked against a queue-fed model.
module tb_du_issue_ctrl;
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, ll;
  } ins_t;

  typedef struct {
    bit        v0, v1;
    bit [1:0]  p0, p1;
    bit        pr, dl;
    bit [31:0] st;
  } exp_t;

  logic clk, reset, pairValid, way1Valid, exReady, wbValid, flush;
  logic [4:0] wbRd;
  ins_t w0, w1;
  logic pairReady_o, duLoad_o, way0_valid_o, way1_valid_o;
  logic [1:0] way0_pID_o, way1_pID_o;
  logic [31:0] stallCycles_o;

  du_issue_ctrl dut (
    .clk(clk), .reset(reset), .pairValid_i(pairValid), .way1Valid_i(way1Valid),
    .way0_rs1Addr_i(w0.rs1), .way0_rs2Addr_i(w0.rs2), .way0_rdAddr_i(w0.rd),
    .way0_rs1Use_i(w0.u1), .way0_rs2Use_i(w0.u2), .way0_rdWriteEnable_i(w0.we),
    .way0_longLat_i(w0.ll),
    .way1_rs1Addr_i(w1.rs1), .way1_rs2Addr_i(w1.rs2), .way1_rdAddr_i(w1.rd),
    .way1_rs1Use_i(w1.u1), .way1_rs2Use_i(w1.u2), .way1_rdWriteEnable_i(w1.we),
    .way1_longLat_i(w1.ll),
    .exReady_i(exReady), .wbValid_i(wbValid), .wbRdAddr_i(wbRd), .flush_i(flush),
    .pairReady_o(pairReady_o), .duLoad_o(duLoad_o), .way0_valid_o(way0_valid_o),
    .way1_valid_o(way1_valid_o), .way0_pID_o(way0_pID_o), .way1_pID_o(way1_pID_o),
    .stallCycles_o(stallCycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: which registers await a writeback, whether the
  // current pair is half issued, next tag and stall total.
  bit     busy_m[32];
  bit     half;
  int     pid_m;
  longint stall_m;
  bit     last_pr;
  exp_t   expq[$];
  int     n_vec, n_bad;

  function automatic bit waits(bit use_, bit [4:0] a);
    return use_ && a != 5'd0 && busy_m[a];
  endfunction

  function automatic ins_t mk(int rs1, int rs2, int rd, bit u1, bit u2, bit we, bit ll);
    ins_t r;
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.u1 = u1; r.u2 = u2; r.we = we; r.ll = ll;
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
  endfunction

  task automatic model_push();
    exp_t e;
    bit   iss0, iss1, dep;
    int   n;
    e = '{default: 0};
    iss0 = 0; iss1 = 0;
    if (reset) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      half = 0; pid_m = 0; stall_m = 0; last_pr = 1;
      expq.push_back(e);
      return;
    end
    e.dl = exReady || flush;
    e.st = stall_m[31:0];
    if (flush) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      half = 0; pid_m = 0; last_pr = 1;
      expq.push_back(e);
      return;
    end
    if (exReady && pairValid) begin
      if (!half) begin
        if (!(waits(w0.u1, w0.rs1) || waits(w0.u2, w0.rs2))) begin
          iss0 = 1;
          dep = waits(w1.u1, w1.rs1) || waits(w1.u2, w1.rs2) ||
                (w0.we && w0.rd != 0 && ((w1.u1 && w1.rs1 == w0.rd) || (w1.u2 && w1.rs2 == w0.rd))) ||
                (w0.we && w1.we && w0.rd == w1.rd && w0.rd != 0);
          if (way1Valid && dep) half = 1;
          else begin iss1 = way1Valid; e.pr = 1; end
        end
      end else if (!(waits(w1.u1, w1.rs1) || waits(w1.u2, w1.rs2))) begin
        iss1 = 1; e.pr = 1; half = 0;
      end
      n = 0;
      if (iss0) begin e.v0 = 1; e.p0 = 2'((pid_m + n) % 4); n++; end
      if (iss1) begin e.v1 = 1; e.p1 = 2'((pid_m + n) % 4); n++; end
      pid_m = (pid_m + n) % 4;
      if (n == 0 && stall_m < 64'hFFFF_FFFF) stall_m++;
    end
    if (wbValid && wbRd != 0) busy_m[wbRd] = 0;
    if (iss0 && w0.ll && w0.we && w0.rd != 0) busy_m[w0.rd] = 1;
    if (iss1 && w1.ll && w1.we && w1.rd != 0) busy_m[w1.rd] = 1;
    last_pr = e.pr;
    expq.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h model=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected record per presented cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("way0_valid", 32'(way0_valid_o), 32'(e.v0));
        check("way1_valid", 32'(way1_valid_o), 32'(e.v1));
        if (e.v0) check("way0_pID", 32'(way0_pID_o), 32'(e.p0));
        if (e.v1) check("way1_pID", 32'(way1_pID_o), 32'(e.p1));
        check("pairReady", 32'(pairReady_o), 32'(e.pr));
        check("duLoad", 32'(duLoad_o), 32'(e.dl));
        check("stallCycles", stallCycles_o, e.st);
      end
    end
  end

  task automatic step();
    #1;
    model_push();
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1; pairValid = 1; way1Valid = 1; exReady = 1;
    wbValid = 0; wbRd = 0; flush = 0;
    w0 = mk(3, 3, 1, 1, 1, 1, 0);
    w1 = mk(3, 3, 2, 1, 1, 1, 0);
    @(negedge clk);
    repeat (2) step();
    reset = 0;
    step();                                  // independent dual issue
    w0 = mk(1, 2, 5, 1, 1, 1, 0);
    w1 = mk(5, 0, 6, 1, 0, 1, 0);
    repeat (2) step();                       // RAW split
    way1Valid = 0;
    w0 = mk(1, 0, 7, 1, 0, 1, 1);
    step();                                  // load x7
    w0 = mk(7, 0, 8, 1, 0, 1, 0);
    repeat (3) step();
    wbValid = 1; wbRd = 7;
    step();
    wbValid = 0;
    step();                                  // issues after writeback
    w0 = mk(1, 0, 7, 1, 0, 1, 1);
    step();
    wbValid = 1;
    step();                                  // clear and new load to x7 together
    wbValid = 0;
    w0 = mk(7, 0, 8, 1, 0, 1, 0);
    step();
    wbValid = 1;
    step();
    wbValid = 0;
    step();
    w0 = mk(1, 0, 9, 1, 0, 1, 1);
    step();                                  // load x9
    way1Valid = 1;
    w0 = mk(1, 1, 10, 1, 1, 1, 0);
    w1 = mk(9, 0, 11, 1, 0, 1, 0);
    step();                                  // split on busy x9
    flush = 1; exReady = 0;
    step();
    flush = 0; exReady = 1;
    step();                                  // dual, tags restart at 0
    way1Valid = 0;
    w0 = mk(1, 0, 9, 1, 0, 1, 1);
    step();
    way1Valid = 1;
    w0 = mk(1, 1, 10, 1, 1, 1, 0);
    step();                                  // split again
    reset = 1;
    step();
    reset = 0;
    step();
    w0 = mk(1, 1, 2, 1, 1, 1, 0);
    w1 = mk(3, 3, 4, 1, 1, 1, 0);
    repeat (3) step();
    exReady = 0;
    repeat (2) step();
    exReady = 1;
    repeat (4) step();

    last_pr = 1;
    for (int c = 0; c < 3000; c++) begin
      if (last_pr) begin
        w0 = rnd_ins();
        w1 = rnd_ins();
        way1Valid = $urandom_range(0, 4) != 0;
      end
      reset     = $urandom_range(0, 299) == 0;
      flush     = $urandom_range(0, 39) == 0;
      exReady   = $urandom_range(0, 4) != 0;
      pairValid = $urandom_range(0, 6) != 0;
      wbValid   = $urandom_range(0, 2) == 0;
      wbRd      = 5'($urandom_range(0, 7));
      step();
    end

    reset = 0; flush = 0; pairValid = 0; wbValid = 0;
    repeat (2) step();
    #3;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
